// File: rtl/cmod_s7_ui_ctrl.sv
// Two-button user interface for the Cmod S7 receiver: short/long press decoding,
// LED mode selection, mute with blinking indicator and a saturating gain step.
module cmod_s7_ui_ctrl #(
   parameter int CLK_FREQ      = 12000000,
   parameter int LONG_PRESS_MS = 1000,
   parameter int BLINK_HZ      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] btn_i,
   input  logic [3:0] strength_i,
   input  logic       valid_i,
   output logic [3:0] led_o,
   output logic       led0_r_o,
   output logic       led0_g_o,
   output logic       led0_b_o,
   output logic       mute_o,
   output logic [2:0] gain_o
);

   localparam int LP_CYC = CLK_FREQ / 1000 * LONG_PRESS_MS;
   localparam int HALF   = CLK_FREQ / (2 * BLINK_HZ);
   localparam int HW     = $clog2(LP_CYC + 1);
   localparam int BW     = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [HW-1:0] LP_MAX   = HW'(LP_CYC);
   localparam logic [HW-1:0] LP_PRE   = HW'(LP_CYC - 1);
   localparam logic [BW-1:0] HALF_MAX = BW'(HALF - 1);

   typedef enum logic [1:0] {
      MODE_BAR = 2'd0,
      MODE_BIN = 2'd1,
      MODE_OFF = 2'd2
   } mode_e;

   logic [1:0]         btn_q;
   logic [1:0][HW-1:0] hold_q, hold_d;
   logic [1:0]         short_ev, long_ev;
   mode_e              mode_q, mode_d;
   logic               mute_q, mute_d;
   logic [2:0]         gain_q, gain_d;
   logic [BW-1:0]      blink_q, blink_d;
   logic               phase_q, phase_d;
   logic [3:0]         led_q, led_d;
   logic               red_q, red_d;
   logic               grn_q, grn_d;
   logic               blu_q, blu_d;

   // A release after the counter saturated already produced its long event.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         hold_d[b]   = '0;
         short_ev[b] = 1'b0;
         long_ev[b]  = 1'b0;
         if (btn_i[b]) begin
            hold_d[b]  = (hold_q[b] == LP_MAX) ? LP_MAX : hold_q[b] + HW'(1);
            long_ev[b] = (hold_q[b] == LP_PRE);
         end else begin
            short_ev[b] = btn_q[b] && (hold_q[b] < LP_MAX);
         end
      end
   end

   always_comb begin
      mode_d = mode_q;
      if (short_ev[0]) begin
         case (mode_q)
            MODE_BAR: mode_d = MODE_BIN;
            MODE_BIN: mode_d = MODE_OFF;
            default:  mode_d = MODE_BAR;
         endcase
      end

      mute_d = mute_q ^ long_ev[0];

      gain_d = gain_q;
      if (long_ev[1])
         gain_d = 3'd0;
      else if (short_ev[1] && (gain_q != 3'd7))
         gain_d = gain_q + 3'd1;

      // Restart the blink on mute-on so the indicator always begins lit.
      blink_d = blink_q + BW'(1);
      phase_d = phase_q;
      if (long_ev[0] && !mute_q) begin
         blink_d = '0;
         phase_d = 1'b1;
      end else if (blink_q == HALF_MAX) begin
         blink_d = '0;
         phase_d = ~phase_q;
      end

      led_d = 4'b0000;
      case (mode_q)
         MODE_BAR: begin
            if (strength_i == 4'd0)     led_d = 4'b0000;
            else if (strength_i < 4'd4) led_d = 4'b0001;
            else if (strength_i < 4'd8) led_d = 4'b0011;
            else if (strength_i < 4'd12) led_d = 4'b0111;
            else                        led_d = 4'b1111;
         end
         MODE_BIN: led_d = strength_i;
         default:  led_d = 4'b0000;
      endcase

      red_d = mute_q & phase_q;
      grn_d = valid_i;
      blu_d = |btn_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_q   <= 2'b00;
         hold_q  <= '0;
         mode_q  <= MODE_BAR;
         mute_q  <= 1'b0;
         gain_q  <= 3'd0;
         blink_q <= '0;
         phase_q <= 1'b0;
         led_q   <= 4'b0000;
         red_q   <= 1'b0;
         grn_q   <= 1'b0;
         blu_q   <= 1'b0;
      end else begin
         btn_q   <= btn_i;
         hold_q  <= hold_d;
         mode_q  <= mode_d;
         mute_q  <= mute_d;
         gain_q  <= gain_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
         led_q   <= led_d;
         red_q   <= red_d;
         grn_q   <= grn_d;
         blu_q   <= blu_d;
      end
   end

   assign led_o    = led_q;
   assign led0_r_o = red_q;
   assign led0_g_o = grn_q;
   assign led0_b_o = blu_q;
   assign mute_o   = mute_q;
   assign gain_o   = gain_q;

endmodule

// File: tb/tb_cmod_s7_ui_ctrl.sv
// Directed bench for cmod_s7_ui_ctrl with LP_CYC = 20 and HALF = 10.
module tb_cmod_s7_ui_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] btn_i = 2'b00;
   logic [3:0] strength_i = 4'd9;
   logic       valid_i = 1'b1;
   logic [3:0] led_o;
   logic       led0_r_o, led0_g_o, led0_b_o, mute_o;
   logic [2:0] gain_o;

   int n_vec = 0;
   int n_err = 0;

   cmod_s7_ui_ctrl #(
      .CLK_FREQ(10000),
      .LONG_PRESS_MS(2),
      .BLINK_HZ(500)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_i(btn_i),
      .strength_i(strength_i),
      .valid_i(valid_i),
      .led_o(led_o),
      .led0_r_o(led0_r_o),
      .led0_g_o(led0_g_o),
      .led0_b_o(led0_b_o),
      .mute_o(mute_o),
      .gain_o(gain_o)
   );

   always #5 clk = ~clk;

   // Advance n rising edges and settle just after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_vec++; if (led_o !== 4'b0000) begin n_err++; $display("FAIL reset_led: got %b want 0000", led_o); end
      n_vec++; if ({led0_r_o, led0_g_o, led0_b_o} !== 3'b000) begin n_err++; $display("FAIL reset_rgb: got %b want 000", {led0_r_o, led0_g_o, led0_b_o}); end
      n_vec++; if (mute_o !== 1'b0) begin n_err++; $display("FAIL reset_mute: got %b want 0", mute_o); end
      n_vec++; if (gain_o !== 3'd0) begin n_err++; $display("FAIL reset_gain: got %0d want 0", gain_o); end
      @(posedge clk); #1;
      rst = 1'b1;
      step(1);
      n_vec++; if (led_o !== 4'b0111) begin n_err++; $display("FAIL bar_after_reset: got %b want 0111", led_o); end
      n_vec++; if (led0_g_o !== 1'b1) begin n_err++; $display("FAIL green_valid: got %b want 1", led0_g_o); end
   endtask

   task automatic test_mode_cycle();
      btn_i[0] = 1'b1;
      step(5);
      n_vec++; if (led0_b_o !== 1'b1) begin n_err++; $display("FAIL blue_pressed: got %b want 1", led0_b_o); end
      btn_i[0] = 1'b0;
      step(1);
      n_vec++; if (led_o !== 4'b0111) begin n_err++; $display("FAIL led_at_release_edge: got %b want 0111", led_o); end
      step(1);
      n_vec++; if (led_o !== 4'b1001) begin n_err++; $display("FAIL mode_bin: got %b want 1001", led_o); end
      n_vec++; if (led0_b_o !== 1'b0) begin n_err++; $display("FAIL blue_released: got %b want 0", led0_b_o); end
      btn_i[0] = 1'b1; step(5); btn_i[0] = 1'b0; step(2);
      n_vec++; if (led_o !== 4'b0000) begin n_err++; $display("FAIL mode_off: got %b want 0000", led_o); end
      btn_i[0] = 1'b1; step(5); btn_i[0] = 1'b0; step(2);
      n_vec++; if (led_o !== 4'b0111) begin n_err++; $display("FAIL mode_bar_again: got %b want 0111", led_o); end
   endtask

   task automatic test_mute_blink();
      logic exp_r;
      btn_i[0] = 1'b1;
      step(19);
      n_vec++; if (mute_o !== 1'b0) begin n_err++; $display("FAIL mute_before_long: got %b want 0", mute_o); end
      step(1);
      n_vec++; if (mute_o !== 1'b1) begin n_err++; $display("FAIL mute_at_20: got %b want 1", mute_o); end
      n_vec++; if (led0_r_o !== 1'b0) begin n_err++; $display("FAIL red_at_20: got %b want 0", led0_r_o); end
      for (int i = 21; i <= 40; i++) begin
         step(1);
         if (i == 30) btn_i[0] = 1'b0;
         exp_r = (i <= 30);
         n_vec++; if (led0_r_o !== exp_r) begin n_err++; $display("FAIL red_blink_%0d: got %b want %b", i, led0_r_o, exp_r); end
      end
      n_vec++; if (led_o !== 4'b0111) begin n_err++; $display("FAIL no_mode_after_long: got %b want 0111", led_o); end
      n_vec++; if (mute_o !== 1'b1) begin n_err++; $display("FAIL mute_held: got %b want 1", mute_o); end
      btn_i[0] = 1'b1; step(20); btn_i[0] = 1'b0; step(2);
      n_vec++; if (mute_o !== 1'b0) begin n_err++; $display("FAIL unmute: got %b want 0", mute_o); end
      n_vec++; if (led0_r_o !== 1'b0) begin n_err++; $display("FAIL red_unmuted: got %b want 0", led0_r_o); end
   endtask

   task automatic test_gain();
      logic [2:0] exp_g;
      for (int k = 1; k <= 9; k++) begin
         btn_i[1] = 1'b1; step(3); btn_i[1] = 1'b0; step(1);
         exp_g = (k > 7) ? 3'd7 : 3'(k);
         n_vec++; if (gain_o !== exp_g) begin n_err++; $display("FAIL gain_short_%0d: got %0d want %0d", k, gain_o, exp_g); end
         step(1);
      end
      btn_i[1] = 1'b1;
      step(19);
      n_vec++; if (gain_o !== 3'd7) begin n_err++; $display("FAIL gain_before_long: got %0d want 7", gain_o); end
      step(1);
      n_vec++; if (gain_o !== 3'd0) begin n_err++; $display("FAIL gain_long_clear: got %0d want 0", gain_o); end
      btn_i[1] = 1'b0; step(2);
      n_vec++; if (gain_o !== 3'd0) begin n_err++; $display("FAIL gain_after_long_release: got %0d want 0", gain_o); end
   endtask

   task automatic test_bar_thermo();
      logic [3:0] s_tab [6];
      logic [3:0] e_tab [6];
      s_tab = '{4'd0, 4'd3, 4'd4, 4'd11, 4'd12, 4'd15};
      e_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
      for (int i = 0; i < 6; i++) begin
         strength_i = s_tab[i];
         step(1);
         n_vec++; if (led_o !== e_tab[i]) begin n_err++; $display("FAIL bar_s%0d: got %b want %b", s_tab[i], led_o, e_tab[i]); end
      end
   endtask

   task automatic test_simultaneous();
      strength_i = 4'd5;
      btn_i = 2'b11;
      step(4);
      btn_i = 2'b00;
      step(1);
      n_vec++; if (gain_o !== 3'd1) begin n_err++; $display("FAIL simul_gain: got %0d want 1", gain_o); end
      n_vec++; if (led_o !== 4'b0011) begin n_err++; $display("FAIL simul_led_old: got %b want 0011", led_o); end
      step(1);
      n_vec++; if (led_o !== 4'b0101) begin n_err++; $display("FAIL simul_mode_bin: got %b want 0101", led_o); end
   endtask

   task automatic test_reset_mid();
      btn_i[0] = 1'b1;
      step(15);
      n_vec++; if (led0_b_o !== 1'b1) begin n_err++; $display("FAIL pre_reset_blue: got %b want 1", led0_b_o); end
      #2;
      rst = 1'b0;
      #1;
      n_vec++; if (led_o !== 4'b0000) begin n_err++; $display("FAIL midreset_led: got %b want 0000", led_o); end
      n_vec++; if (gain_o !== 3'd0) begin n_err++; $display("FAIL midreset_gain: got %0d want 0", gain_o); end
      n_vec++; if ({led0_r_o, led0_g_o, led0_b_o} !== 3'b000) begin n_err++; $display("FAIL midreset_rgb: got %b want 000", {led0_r_o, led0_g_o, led0_b_o}); end
      @(posedge clk); #1;
      rst = 1'b1;
      step(19);
      n_vec++; if (mute_o !== 1'b0) begin n_err++; $display("FAIL held_reset_mute_19: got %b want 0", mute_o); end
      n_vec++; if (led_o !== 4'b0011) begin n_err++; $display("FAIL held_reset_bar: got %b want 0011", led_o); end
      step(1);
      n_vec++; if (mute_o !== 1'b1) begin n_err++; $display("FAIL held_reset_long_20: got %b want 1", mute_o); end
      btn_i[0] = 1'b0;
      step(2);
      n_vec++; if (led_o !== 4'b0011) begin n_err++; $display("FAIL held_reset_no_short: got %b want 0011", led_o); end
   endtask

   initial begin
      test_reset();
      test_mode_cycle();
      test_mute_blink();
      test_gain();
      test_bar_thermo();
      test_simultaneous();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cmod_s7_ui_ctrl.md
CMOD_S7_UI_CTRL -- requirements
Module: cmod_s7_ui_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter CLK_FREQ, default 12000000, clock frequency in Hz.
REQ-003 SHALL have parameter LONG_PRESS_MS, default 1000, hold time for a long press; LP_CYC = CLK_FREQ/1000*LONG_PRESS_MS.
REQ-004 SHALL have parameter BLINK_HZ, default 2, mute-indicator blink rate; HALF = CLK_FREQ/(2*BLINK_HZ).
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port btn_i  input  2  debounced buttons from the board-support block, 1 = pressed.
REQ-008 SHALL have port strength_i  input  4  receiver signal strength, 0..15.
REQ-009 SHALL have port valid_i  input  1  receiver lock indication.
REQ-010 SHALL have port led_o  output  4  LED request to the board-support LED input.
REQ-011 SHALL have ports led0_r_o, led0_g_o, led0_b_o  output  1 each  RGB LED requests.
REQ-012 SHALL have port mute_o  output  1  audio mute state.
REQ-013 SHALL have port gain_o  output  3  receiver gain step, 0..7.

Function
REQ-014 SHALL register btn_i each cycle into btn_q; per button, a 1-to-0 transition (btn_i=0, btn_q=1) is a release.
REQ-015 SHALL keep a per-button hold counter: cleared while btn_i=0, incremented while btn_i=1, saturating at LP_CYC.
REQ-016 SHALL fire a long event exactly once per press, in the cycle the counter advances from LP_CYC-1 to LP_CYC.
REQ-017 SHALL fire a short event on release only if the counter is below LP_CYC; a release after a long event fires nothing.
REQ-018 SHALL update mode, mute and gain registers at the same clock edge at which the event is detected.
REQ-019 SHALL cycle mode on btn 0 short: BAR -> BIN -> OFF -> BAR.
REQ-020 SHALL toggle mute_o on btn 0 long.
REQ-021 SHALL increment gain_o on btn 1 short, saturating at 7.
REQ-022 SHALL clear gain_o to 0 on btn 1 long.
REQ-023 SHALL process both buttons independently; simultaneous events SHALL both take effect in the same cycle.
REQ-024 SHALL register led_o from the current mode one cycle after a mode change (2 cycles after the release edge).
REQ-025 SHALL drive led_o in BAR as a thermometer: strength 0 -> 0000, 1-3 -> 0001, 4-7 -> 0011, 8-11 -> 0111, 12-15 -> 1111.
REQ-026 SHALL drive led_o in BIN as strength_i, and in OFF as 0000.
REQ-027 SHALL run a blink counter 0..HALF-1 that toggles phase on wrap.
REQ-028 SHALL, when mute turns on, load counter = 0 and phase = 1 in the same cycle.
REQ-029 SHALL register led0_r_o as mute & phase, led0_g_o as valid_i, and led0_b_o as OR of btn_i.

Reset
REQ-030 SHALL, on rst=0, asynchronously clear btn_q, hold counters, blink counter and phase, mode = BAR, mute_o = 0, gain_o = 0, led_o = 0000, and all RGB outputs = 0.
REQ-031 SHALL treat a button held across reset release as a new press with counter starting from 0 and btn_q = 0; it fires no event until its release or LP_CYC.

Verification (CLK_FREQ=10000, LONG_PRESS_MS=2 so LP_CYC=20, BLINK_HZ=500 so HALF=10)
REQ-032 SHALL verify: btn0 held 5 cycles then released -> mode BIN; led_o = strength_i 2 cycles after the release edge; a second short press -> led_o = 0000.
REQ-033 SHALL verify: btn0 held 30 cycles -> mute_o = 1 at the 20th held cycle; no mode change on release; led0_r_o high for 10 cycles then low for 10.
REQ-034 SHALL verify: 9 btn1 short presses -> gain_o = 7; a btn1 long press -> gain_o = 0.
REQ-035 SHALL verify: strength_i stepped 0, 3, 4, 11, 12, 15 in BAR -> led_o = 0000, 0001, 0011, 0111, 1111, 1111.
REQ-036 SHALL verify: btn0 short and btn1 short released in the same cycle -> mode and gain both advance.
REQ-037 SHALL verify: rst asserted at hold count 15 -> all outputs clear immediately; after release, the held button fires a long event 20 cycles later.
